ivector_rr_arbiter: RTL and testbench

//  Parametrised indication vector. Each say(meth,v) call lands in one of NUM_CHANNELS
//  per-channel FIFOs selected by meth. A round-robin arbiter drains non-empty channels

---
 rtl/ivector_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_ivector_rr_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ivector_rr_arbiter.sv
// Indication vector: say() calls are buffered in per-channel FIFOs selected by meth,
// and a round-robin arbiter drains the non-empty channels onto a single heard() port.
module ivector_rr_arbiter #(
   parameter int NUM_CHANNELS = 11,
   parameter int DEPTH        = 4,
   parameter int DATA_WIDTH   = 32,
   parameter int METH_WIDTH   = 32
) (
   input  logic                  CLK,
   input  logic                  nRST,
   input  logic                  say__ENA,
   input  logic [METH_WIDTH-1:0] say_meth,
   input  logic [DATA_WIDTH-1:0] say_v,
   output logic                  say__RDY,
   output logic                  ind_heard__ENA,
   output logic [METH_WIDTH-1:0] ind_heard_heard_meth,
   output logic [DATA_WIDTH-1:0] ind_heard_heard_v,
   input  logic                  ind_heard__RDY,
   output logic [31:0]           vsize,
   output logic [31:0]           drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [AW:0]           CNT_FULL   = (AW+1)'(DEPTH);
   localparam logic [METH_WIDTH-1:0] METH_LIMIT = METH_WIDTH'(NUM_CHANNELS);
   localparam logic [CW-1:0]         LAST_CH    = CW'(NUM_CHANNELS - 1);

   logic [NUM_CHANNELS-1:0] w_full;
   logic [NUM_CHANNELS-1:0] w_nonempty;
   logic [DATA_WIDTH-1:0]   w_head [NUM_CHANNELS];
   logic                    w_in_range;
   logic                    w_say_full;
   logic                    w_say_fire;
   logic                    w_enq_ok;
   logic                    w_any;
   logic                    w_ena;
   logic [CW-1:0]           w_grant;
   logic [CW-1:0]           r_ptr;
   logic [31:0]             r_vsize;
   logic [31:0]             r_drop;

   assign w_in_range = (say_meth < METH_LIMIT);

   always_comb begin
      w_say_full = 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (say_meth == METH_WIDTH'(i)) w_say_full = w_full[i];
      end
   end

   // Full uses only the registered count, so a same-cycle pop never grants extra room.
   assign say__RDY   = nRST & (~w_in_range | ~w_say_full);
   assign w_say_fire = say__ENA & say__RDY;
   assign w_enq_ok   = w_say_fire & w_in_range;

   // Rotating scan starting at the round-robin pointer.
   always_comb begin
      int   v_idx;
      logic v_found;
      v_idx   = 0;
      v_found = 1'b0;
      w_grant = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         v_idx = int'(r_ptr) + i;
         if (v_idx >= NUM_CHANNELS) v_idx = v_idx - NUM_CHANNELS;
         if (!v_found && w_nonempty[CW'(v_idx)]) begin
            v_found = 1'b1;
            w_grant = CW'(v_idx);
         end
      end
   end

   assign w_any = |w_nonempty;
   assign w_ena = nRST & w_any & ind_heard__RDY;

   assign ind_heard__ENA       = w_ena;
   assign ind_heard_heard_meth = w_any ? METH_WIDTH'(w_grant) : '0;
   assign ind_heard_heard_v    = w_any ? w_head[w_grant] : '0;

   generate
      for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
         logic [DATA_WIDTH-1:0] r_mem [DEPTH];
         logic [AW-1:0]         r_wp;
         logic [AW-1:0]         r_rp;
         logic [AW:0]           r_cnt;
         logic                  w_enq;
         logic                  w_deq;

         assign w_enq = w_enq_ok & (say_meth == METH_WIDTH'(gi));
         assign w_deq = w_ena & (w_grant == CW'(gi));

         // Storage needs no reset: the count alone decides which entries are live.
         always_ff @(posedge CLK) begin
            if (w_enq) r_mem[r_wp] <= say_v;
         end

         always_ff @(posedge CLK) begin
            if (!nRST) begin
               r_wp  <= '0;
               r_rp  <= '0;
               r_cnt <= '0;
            end else begin
               if (w_enq) r_wp <= r_wp + AW'(1);
               if (w_deq) r_rp <= r_rp + AW'(1);
               if (w_enq && !w_deq)      r_cnt <= r_cnt + (AW+1)'(1);
               else if (!w_enq && w_deq) r_cnt <= r_cnt - (AW+1)'(1);
            end
         end

         assign w_full[gi]     = (r_cnt == CNT_FULL);
         assign w_nonempty[gi] = (r_cnt != '0);
         assign w_head[gi]     = r_mem[r_rp];
      end
   endgenerate

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_ptr   <= '0;
         r_vsize <= '0;
         r_drop  <= '0;
      end else begin
         if (w_ena) r_ptr <= (w_grant == LAST_CH) ? '0 : w_grant + CW'(1);
         r_vsize <= r_vsize + {31'b0, w_enq_ok} - {31'b0, w_ena};
         if (w_say_fire && !w_in_range && r_drop != '1) r_drop <= r_drop + 32'd1;
      end
   end

   assign vsize      = r_vsize;
   assign drop_count = r_drop;

endmodule

// File: tb/tb_ivector_rr_arbiter.sv
// Randomized and directed bench for ivector_rr_arbiter against a queue-based reference model.
module tb_ivector_rr_arbiter;

   localparam int NCH   = 11;
   localparam int DEPTH = 4;

   logic        clk;
   logic        nrst;
   logic        say_ena;
   logic [31:0] say_meth;
   logic [31:0] say_v;
   logic        say_rdy;
   logic        heard_ena;
   logic [31:0] heard_meth;
   logic [31:0] heard_v;
   logic        heard_rdy;
   logic [31:0] vsize;
   logic [31:0] drop_count;

   ivector_rr_arbiter #(
      .NUM_CHANNELS(NCH),
      .DEPTH(DEPTH),
      .DATA_WIDTH(32),
      .METH_WIDTH(32)
   ) dut (
      .CLK(clk),
      .nRST(nrst),
      .say__ENA(say_ena),
      .say_meth(say_meth),
      .say_v(say_v),
      .say__RDY(say_rdy),
      .ind_heard__ENA(heard_ena),
      .ind_heard_heard_meth(heard_meth),
      .ind_heard_heard_v(heard_v),
      .ind_heard__RDY(heard_rdy),
      .vsize(vsize),
      .drop_count(drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total_cnt = 0;
   int bad_cnt   = 0;
   bit chk_en    = 1'b0;

   // Reference model: one queue per channel, a rotating start index, a drop counter.
   logic [31:0] mq [NCH][$];
   int          m_ptr  = 0;
   longint      m_drop = 0;
   logic [63:0] obs_q [$];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input logic rst_n, input logic ena, input logic [31:0] meth,
                       input logic [31:0] v, input logic hrdy);
      bit          e_in, e_rdy, e_any, e_ena, e_fire;
      int          e_cand, e_vsize;
      logic [31:0] e_hm, e_hv;
      @(negedge clk);
      nrst = rst_n; say_ena = ena; say_meth = meth; say_v = v; heard_rdy = hrdy;
      #1;
      e_in  = (meth < NCH);
      e_rdy = rst_n && (!e_in || mq[e_in ? int'(meth) : 0].size() < DEPTH);
      e_any = 1'b0; e_cand = 0; e_vsize = 0;
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = (m_ptr + k) % NCH;
         if (!e_any && mq[c].size() > 0) begin e_any = 1'b1; e_cand = c; end
         e_vsize += mq[k].size();
      end
      e_ena  = rst_n && e_any && hrdy;
      e_hm   = e_any ? 32'(e_cand) : 32'd0;
      e_hv   = e_any ? mq[e_cand][0] : 32'd0;
      e_fire = ena && e_rdy;
      if (chk_en) begin
         check_val("say_rdy", 64'(say_rdy), 64'(e_rdy));
         check_val("heard_ena", 64'(heard_ena), 64'(e_ena));
         check_val("heard_meth", 64'(heard_meth), 64'(e_hm));
         check_val("heard_v", 64'(heard_v), 64'(e_hv));
         check_val("vsize", 64'(vsize), 64'(e_vsize));
         check_val("drop_count", 64'(drop_count), 64'(m_drop));
      end
      if (heard_ena) obs_q.push_back({heard_meth, heard_v});
      @(posedge clk);
      if (!rst_n) begin
         for (int k = 0; k < NCH; k++) mq[k].delete();
         m_ptr = 0; m_drop = 0;
      end else begin
         if (e_ena) begin
            void'(mq[e_cand].pop_front());
            m_ptr = (e_cand + 1) % NCH;
         end
         if (e_fire) begin
            if (e_in) mq[meth].push_back(v);
            else if (m_drop < 64'hFFFF_FFFF) m_drop++;
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
   endtask

   initial begin
      nrst = 1'b0; say_ena = 1'b0; say_meth = '0; say_v = '0; heard_rdy = 1'b0;

      // Reset: first cycle unchecked while registers are still unknown
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      chk_en = 1'b1;
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      check_val("rst_vsize", 64'(vsize), 64'd0);
      check_val("rst_drop", 64'(drop_count), 64'd0);
      check_val("rst_say_rdy", 64'(say_rdy), 64'd1);
      check_val("rst_heard_ena", 64'(heard_ena), 64'd0);

      // Single pass
      obs_q.delete();
      step(1'b1, 1'b1, 32'd3, 32'hA5, 1'b1);
      step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      check_val("single_cnt", 64'(obs_q.size()), 64'd1);
      if (obs_q.size() > 0) check_val("single_item", obs_q[0], {32'd3, 32'hA5});
      check_val("single_vsize", 64'(vsize), 64'd0);

      // Fairness
      do_reset(1);
      obs_q.delete();
      step(1'b1, 1'b1, 32'd0, 32'd1, 1'b0);
      step(1'b1, 1'b1, 32'd0, 32'd2, 1'b0);
      step(1'b1, 1'b1, 32'd5, 32'd7, 1'b0);
      step(1'b1, 1'b1, 32'd10, 32'd9, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      check_val("fair_cnt", 64'(obs_q.size()), 64'd4);
      if (obs_q.size() == 4) begin
         check_val("fair_0", obs_q[0], {32'd0, 32'd1});
         check_val("fair_1", obs_q[1], {32'd5, 32'd7});
         check_val("fair_2", obs_q[2], {32'd10, 32'd9});
         check_val("fair_3", obs_q[3], {32'd0, 32'd2});
      end

      // Full channel
      do_reset(1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'd2, 32'(100 + i), 1'b0);
      step(1'b1, 1'b1, 32'd2, 32'd200, 1'b0);
      step(1'b1, 1'b0, 32'd4, 32'd0, 1'b0);
      #1;
      check_val("full_rdy_ch4", 64'(say_rdy), 64'd1);
      check_val("full_vsize", 64'(vsize), 64'd4);
      say_meth = 32'd2;
      #1;
      check_val("full_rdy_ch2", 64'(say_rdy), 64'd0);

      // Drops
      do_reset(1);
      step(1'b1, 1'b1, 32'd11, 32'd5, 1'b1);
      step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd6, 1'b1);
      step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      check_val("drop_count2", 64'(drop_count), 64'd2);
      check_val("drop_vsize", 64'(vsize), 64'd0);
      check_val("drop_no_ind", 64'(heard_ena), 64'd0);

      // Mid-operation reset
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 32'(i % 3), 32'(i), 1'b0);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
      #1;
      check_val("midrst_vsize", 64'(vsize), 64'd0);
      check_val("midrst_ena", 64'(heard_ena), 64'd0);

      // Randomized traffic, with phases of low downstream readiness to fill FIFOs
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] meth;
         int          r;
         bit          hr;
         r    = int'($urandom_range(0, 15));
         meth = (r == 15) ? 32'hFFFF_FFFF : 32'(r);
         hr   = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0), meth, $urandom, hr);
      end

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
